// File: rtl/sp_mac_pkg.sv
// rtl/sp_mac_pkg.sv - shared types and constants for the systolic MAC scheduler
package sp_mac_pkg;

  localparam int A_W    = 4;
  localparam int B_W    = 8;
  localparam int MIX_W  = 9;
  localparam int ACC_W  = 26;
  localparam int PROD_W = 13;
  // Longest job a 26-bit accumulator absorbs at full 13-bit product magnitude.
  localparam int KLIMIT = 1 << (ACC_W - PROD_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } sched_state_t;

  function automatic logic [MIX_W-1:0] mix_sum(input logic [B_W-1:0] b1, input logic [B_W-1:0] b2);
    return {b1[B_W-1], b1} + {b2[B_W-1], b2};
  endfunction

endpackage

// File: rtl/sp_mac_operand_reg.sv
// rtl/sp_mac_operand_reg.sv - registered row-0 operand/mix/pulse/clear stage; zero forces a flush beat
module sp_mac_operand_reg
  import sp_mac_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             zero,
  input  logic             clear_req,
  input  logic [A_W-1:0]   a1,
  input  logic [A_W-1:0]   a2,
  input  logic [B_W-1:0]   b1,
  input  logic [B_W-1:0]   b2,
  output logic             mac_pulse,
  output logic             mac_clear,
  output logic [A_W-1:0]   mac_a1,
  output logic [A_W-1:0]   mac_a2,
  output logic [B_W-1:0]   mac_b1,
  output logic [B_W-1:0]   mac_b2,
  output logic [MIX_W-1:0] mac_mix
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_pulse <= 1'b0;
      mac_clear <= 1'b0;
      mac_a1    <= '0;
      mac_a2    <= '0;
      mac_b1    <= '0;
      mac_b2    <= '0;
      mac_mix   <= '0;
    end else begin
      mac_pulse <= load | zero;
      mac_clear <= clear_req;
      if (zero) begin
        mac_a1  <= '0;
        mac_a2  <= '0;
        mac_b1  <= '0;
        mac_b2  <= '0;
        mac_mix <= '0;
      end else if (load) begin
        mac_a1  <= a1;
        mac_a2  <= a2;
        mac_b1  <= b1;
        mac_b2  <= b2;
        mac_mix <= mix_sum(b1, b2);
      end
    end
  end

endmodule

// File: rtl/sp_mac_scheduler.sv
// rtl/sp_mac_scheduler.sv - job sequencer for a CHAIN_LEN systolic MAC chain; SP_MAC_SCHED_KLIMIT_EN rejects long jobs
module sp_mac_scheduler
  import sp_mac_pkg::*;
#(
  parameter int CHAIN_LEN = 4,
  parameter int K_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [K_W-1:0]   k_len,
  output logic             busy,
  output logic             err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a1,
  input  logic [A_W-1:0]   in_a2,
  input  logic [B_W-1:0]   in_b1,
  input  logic [B_W-1:0]   in_b2,
  output logic             mac_pulse,
  output logic             mac_clear,
  output logic [A_W-1:0]   mac_a1,
  output logic [A_W-1:0]   mac_a2,
  output logic [B_W-1:0]   mac_b1,
  output logic [B_W-1:0]   mac_b2,
  output logic [MIX_W-1:0] mac_mix,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [K_W-1:0]   beat_cnt
);

  localparam int FL_W = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN - 1) : 1;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'((CHAIN_LEN > 1) ? CHAIN_LEN - 2 : 0);
  localparam sched_state_t POST_STREAM = (CHAIN_LEN > 1) ? ST_FLUSH : ST_DONE;

  sched_state_t    state;
  logic [K_W-1:0]  k_reg;
  logic [FL_W-1:0] flush_cnt;
  logic [K_W-1:0]  beat_nxt;
  logic            beat;
  logic            k_reject;

  assign beat     = in_valid & in_ready;
  assign beat_nxt = beat_cnt + 1'b1;

`ifdef SP_MAC_SCHED_KLIMIT_EN
  assign k_reject = (32'(k_len) > KLIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else          err <= (state == ST_IDLE) && start && k_reject;
  end
`else
  assign k_reject = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      beat_cnt  <= '0;
      k_reg     <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !k_reject) begin
            k_reg <= k_len;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          beat_cnt  <= '0;
          flush_cnt <= '0;
          if (k_reg == '0) begin
            state <= POST_STREAM;
          end else begin
            in_ready <= 1'b1;
            state    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (beat) begin
            beat_cnt <= beat_nxt;
            if (beat_nxt == k_reg) begin
              in_ready <= 1'b0;
              state    <= POST_STREAM;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == FL_LAST) state <= ST_DONE;
          else                      flush_cnt <= flush_cnt + 1'b1;
        end
        ST_DONE: begin
          // One settling cycle so res_valid lands after the final registered pulse.
          if (!res_valid) begin
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sp_mac_operand_reg u_opreg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (beat),
    .zero      (state == ST_FLUSH),
    .clear_req (state == ST_LOAD),
    .a1        (in_a1),
    .a2        (in_a2),
    .b1        (in_b1),
    .b2        (in_b2),
    .mac_pulse (mac_pulse),
    .mac_clear (mac_clear),
    .mac_a1    (mac_a1),
    .mac_a2    (mac_a2),
    .mac_b1    (mac_b1),
    .mac_b2    (mac_b2),
    .mac_mix   (mac_mix)
  );

endmodule

// File: tb/tb_sp_mac_scheduler.sv
// tb/tb_sp_mac_scheduler.sv - scoreboard bench for sp_mac_scheduler (CHAIN_LEN=4); SP_MAC_SCHED_KLIMIT_EN adds the reject case
module tb_sp_mac_scheduler;

  localparam int CL = 4;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          busy, err, in_ready, mac_pulse, mac_clear, res_valid;
  logic          in_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic [3:0]    in_a1 = '0, in_a2 = '0, mac_a1, mac_a2;
  logic [7:0]    in_b1 = '0, in_b2 = '0, mac_b1, mac_b2;
  logic [8:0]    mac_mix;
  logic [KW-1:0] beat_cnt;

  sp_mac_scheduler #(.CHAIN_LEN(CL), .K_W(KW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .k_len(k_len),
    .busy(busy), .err(err), .in_valid(in_valid), .in_ready(in_ready),
    .in_a1(in_a1), .in_a2(in_a2), .in_b1(in_b1), .in_b2(in_b2),
    .mac_pulse(mac_pulse), .mac_clear(mac_clear),
    .mac_a1(mac_a1), .mac_a2(mac_a2), .mac_b1(mac_b1), .mac_b2(mac_b2),
    .mac_mix(mac_mix), .res_valid(res_valid), .res_ready(res_ready),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a1;
    logic [3:0] a2;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [8:0] mix;
  } ent_t;

  ent_t       sbq[$];
  ent_t       mon_e;
  int         total = 0;
  int         bad = 0;
  int         pulse_cnt = 0, clear_cnt = 0, ready_cnt = 0;
  int         model_k = 0, model_beats = 0;
  logic       prev_rv = 1'b0, prev_pulse = 1'b0;
  logic [8:0] cur_mix = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_zeros();
    for (int i = 0; i < CL - 1; i++) sbq.push_back('0);
  endtask

  // Monitor: pops expected beats on every pulse, pushes on every accepted handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mac_pulse) begin
        pulse_cnt++;
        if (sbq.size() == 0) begin
          check("unexpected_pulse", 32'(mac_pulse), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          check("mac_a1", 32'(mac_a1), 32'(mon_e.a1));
          check("mac_a2", 32'(mac_a2), 32'(mon_e.a2));
          check("mac_b1", 32'(mac_b1), 32'(mon_e.b1));
          check("mac_b2", 32'(mac_b2), 32'(mon_e.b2));
          check("mac_mix", 32'(mac_mix), 32'(mon_e.mix));
        end
      end
      if (mac_clear) begin
        clear_cnt++;
        check("clear_without_pulse", 32'(mac_pulse), 32'd0);
      end
      if (in_ready) ready_cnt++;
      if (res_valid && !prev_rv) check("res_valid_after_last_pulse", 32'(prev_pulse), 32'd1);
      prev_rv    = res_valid;
      prev_pulse = mac_pulse;
      if (in_valid && in_ready) begin
        mon_e.a1  = in_a1;
        mon_e.a2  = in_a2;
        mon_e.b1  = in_b1;
        mon_e.b2  = in_b2;
        mon_e.mix = cur_mix;
        sbq.push_back(mon_e);
        model_beats++;
        if (model_beats == model_k) push_zeros();
      end
    end
  end

  task automatic run_job(input int k, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [7:0] b1, input logic [7:0] b2, input int mix_e,
                         input bit toggle, input int hold);
    logic [8:0] mx;
    mx = mix_e[8:0];
    pulse_cnt = 0; clear_cnt = 0; ready_cnt = 0;
    model_k = k; model_beats = 0;
    if (k == 0) push_zeros();
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 400 && !res_valid; c++) begin
      if (!toggle || (c % 2 == 0)) begin
        in_valid = 1'b1; in_a1 = a1; in_a2 = a2; in_b1 = b1; in_b2 = b2; cur_mix = mx;
      end else begin
        in_valid = 1'b0;
        in_a1 = 4'($urandom); in_a2 = 4'($urandom);
        in_b1 = 8'($urandom); in_b2 = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("res_valid_reached", 32'(res_valid), 32'd1);
    check("beat_cnt", 32'(beat_cnt), 32'(k));
    check("pulse_total", 32'(pulse_cnt), 32'(k + CL - 1));
    check("clear_once", 32'(clear_cnt), 32'd1);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    check("busy_in_done", 32'(busy), 32'd1);
    if (k == 0) check("no_in_ready_k0", 32'(ready_cnt), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("res_valid_hold", 32'(res_valid), 32'd1);
      check("busy_hold", 32'(busy), 32'd1);
      if (i == 1) begin start = 1'b1; k_len = KW'(1); end
      if (i == 2) start = 1'b0;
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("busy_after_take", 32'(busy), 32'd0);
    check("res_valid_after_take", 32'(res_valid), 32'd0);
    check("beat_cnt_held", 32'(beat_cnt), 32'(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mac", 32'({mac_pulse, mac_clear, mac_a1, mac_a2, mac_b1, mac_b2, mac_mix}), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    #2 reset_n = 1'b1;

    run_job(3, 4'd1, 4'hF, 8'd10, 8'd20, 30, 1'b0, 0);
    run_job(3, 4'd1, 4'hF, 8'd10, 8'd20, 30, 1'b1, 5);
    run_job(2, 4'd7, 4'h8, 8'd127, 8'd127, 254, 1'b0, 0);
    run_job(2, 4'h8, 4'd7, 8'h80, 8'h80, -256, 1'b0, 0);
    run_job(0, 4'd0, 4'd0, 8'd0, 8'd0, 0, 1'b0, 0);

`ifdef SP_MAC_SCHED_KLIMIT_EN
    start = 1'b1;
    k_len = KW'(9000);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("klimit_err_pulse", 32'(err), 32'd1);
    check("klimit_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("klimit_err_one_cycle", 32'(err), 32'd0);
    check("klimit_stays_idle", 32'(busy), 32'd0);
`endif

    // Reset during FLUSH, then a clean job.
    pulse_cnt = 0; clear_cnt = 0; model_k = 2; model_beats = 0;
    start = 1'b1;
    k_len = KW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_a1 = 4'd3; in_a2 = 4'hE; in_b1 = 8'd5; in_b2 = 8'hF9; cur_mix = 9'h1FE;
    for (int c = 0; c < 50 && model_beats < 2; c++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("reached_flush", 32'(model_beats), 32'd2);
    @(posedge clk); #3;
    check("pulse_before_reset", 32'(mac_pulse), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_ctrl", 32'({busy, err, in_ready, res_valid}), 32'd0);
    check("async_rst_mac", 32'({mac_pulse, mac_clear, mac_a1, mac_a2, mac_b1, mac_b2, mac_mix}), 32'd0);
    check("async_rst_beat_cnt", 32'(beat_cnt), 32'd0);
    sbq.delete();
    prev_rv = 1'b0;
    prev_pulse = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    run_job(3, 4'd2, 4'd5, 8'd100, 8'hC8, 44, 1'b0, 0);

`ifndef SP_MAC_SCHED_KLIMIT_EN
    check("err_tied_low", 32'(err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_mac_scheduler.md
# sp_mac_scheduler

Sequencer for a chain of CHAIN_LEN systolic int4×int8 double-MAC units. It accepts a valid/ready operand stream and runs one job: clear, K accumulate beats, then a zero flush of CHAIN_LEN-1 beats. It drives the shared pulse, clear and row-0 operand bus (including the precomputed 9-bit mix = b1+b2), then holds a result-valid handshake until the downstream reader takes the accumulators.

## Interface
- CHAIN_LEN, 4, number of MAC units in the chain (≥1); sets flush length
- K_W, 16, width of the job length field
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  job request; sampled only in IDLE
- k_len  in  K_W  accumulate beats for the job; sampled with start
- busy  out  1  high from accepted start until result handshake completes
- err  out  1  one-cycle pulse: start rejected (see Configuration)
- in_valid / in_ready  in / out  1 / 1  operand stream handshake
- in_a1, in_a2  in  4 each  signed int4 operands
- in_b1, in_b2  in  8 each  signed int8 operands
- mac_pulse  out  1  advance/accumulate strobe to every unit
- mac_clear  out  1  synchronous accumulator clear to every unit
- mac_a1, mac_a2  out  4 each  row-0 int4 operands
- mac_b1, mac_b2  out  8 each  row-0 int8 operands
- mac_mix  out  9  sext(mac_b1)+sext(mac_b2)
- res_valid / res_ready  out / in  1 / 1  accumulator results stable / taken
- beat_cnt  out  K_W  beats accepted in current job

## Operation
- States: IDLE → LOAD → STREAM → FLUSH → DONE → IDLE.
- IDLE: start=1 latches k_len, goes to LOAD. start in any other state is ignored.
- LOAD: one cycle; registers mac_clear=1 for the following cycle. Next state is STREAM, or FLUSH if k_len=0.
- STREAM: in_ready=1. Each in_valid&in_ready beat increments beat_cnt and registers the operands, mix and mac_pulse=1 for the next cycle. A cycle without a beat registers mac_pulse=0; operands hold. The beat that takes beat_cnt to k_len moves the FSM to FLUSH, or to DONE if CHAIN_LEN=1.
- FLUSH: CHAIN_LEN-1 consecutive cycles of mac_pulse=1 with all operands and mix at 0, giving zero products. Then DONE.
- DONE: res_valid=1 until res_ready=1, then IDLE. beat_cnt holds until the next LOAD clears it.
- Arithmetic: mix is a 9-bit signed sum with no saturation. The range −256..254 is exact.

## Timing
- Reset values: every output is 0 (busy, err, in_ready, mac_*, res_valid, beat_cnt).
- All mac_* outputs are registered: a beat accepted at edge t appears on mac_* from t+1 for one cycle.
- mac_clear is high exactly one cycle, before the first mac_pulse. It never coincides with mac_pulse.
- Total mac_pulse cycles per job = k_len + CHAIN_LEN − 1.
- res_valid rises the cycle after the last mac_pulse cycle.
- res_valid&res_ready in the same cycle: IDLE next cycle, busy drops, and a new start is accepted that cycle.
- in_ready is low in all states except STREAM. A valid offered while in_ready is low is not consumed.
- reset_n asserted mid-job: immediate return to IDLE with reset values. No partial handshake survives.

## Configuration
- SP_MAC_SCHED_KLIMIT_EN defined: start with k_len > 8192 is rejected. err pulses one cycle, the FSM stays IDLE and busy stays 0. 8192 is the beat count a 26-bit accumulator holds without overflow at 13-bit product magnitude.
- Undefined: every k_len is accepted and err is tied 0.

## Structure
- Shared package sp_mac_pkg: state enum; constants for operand widths (4/8), MIX_W=9, ACC_W=26, PROD_W=13, and KLIMIT=8192.
- One sub-module, sp_mac_operand_reg: the registered operand/mix/pulse/clear output stage with a zero-force input for FLUSH.
- Control FSM and counters stay in the top module.

## Test plan
- CHAIN_LEN=4, k_len=3, in_valid held 1, a1=1 a2=−1 b1=10 b2=20 → mac_clear 1 cycle; mac_pulse 6 consecutive cycles; mac_mix=30 on the first 3 and 0 on the last 3; res_valid the next cycle; beat_cnt=3.
- Same job with in_valid toggling 1,0,1,0,1 → in_ready high throughout STREAM; mac_pulse gaps mirror the gaps; still 3 stream + 3 flush pulses.
- b1=127, b2=127 → mac_mix=254; b1=−128, b2=−128 → mac_mix=−256.
- k_len=0 → LOAD, 3 flush pulses, res_valid, no in_ready assertion. With SP_MAC_SCHED_KLIMIT_EN, k_len=9000 → err pulse, busy stays 0.
- res_ready held low 5 cycles → res_valid and busy hold, and start is ignored. Then res_ready=1 with start=1 in the next cycle → new job's mac_clear appears.
- reset_n pulsed low during FLUSH → all outputs 0 asynchronously; a subsequent start runs a clean full job.
